// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and prefetch FIFO feeding decode, flushed by branch redirects.
module instr_fetch_unit #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'd0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [31:0]                   imem_addr,
  input  logic [31:0]                   imem_data,
  input  logic                          branch_valid,
  input  logic [31:0]                   branch_target,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_instr,
  output logic [31:0]                   out_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   pcs_q [FIFO_DEPTH];
  logic [31:0]   ins_q [FIFO_DEPTH];
  logic          pop, fetch, push;
  assign pop   = out_valid & out_ready;
  assign fetch = (cnt_q < (AW+1)'(FIFO_DEPTH)) | pop;
  assign push  = fetch & ~branch_valid;
  // A branch still lets the head pop (decode took it) but drops everything else.
  always_comb begin
    pc_d  = branch_valid ? branch_target : push ? pc_q + 32'd1 : pc_q;
    rd_d  = branch_valid ? '0 : rd_q + AW'(pop);
    wr_d  = branch_valid ? '0 : wr_q + AW'(push);
    cnt_d = branch_valid ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pcs_q[i] <= '0;
        ins_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (push) begin
        pcs_q[wr_q] <= pc_q;
        ins_q[wr_q] <= imem_data;
      end
    end
  end
  assign imem_addr  = pc_q;
  assign out_valid  = cnt_q != '0;
  assign out_pc     = pcs_q[rd_q];
  assign out_instr  = ins_q[rd_q];
  assign fifo_count = cnt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: vector table, hand sequences and random traffic against a queue model.
module tb_instr_fetch_unit;
  localparam int D = 2;
  logic        clk = 0, rst = 1;
  logic [31:0] imem_addr, imem_data, branch_target = 0, out_instr, out_pc;
  logic        branch_valid = 0, out_valid, out_ready = 0;
  logic [1:0]  fifo_count;
  int errors = 0, checks = 0;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        q[$];
  logic [31:0] pc_m;
  typedef struct {
    bit rdy; bit br; logic [31:0] tgt;
    bit v; logic [31:0] pc; int cnt; logic [31:0] addr;
  } vec_t;
  vec_t tbl[18];

  instr_fetch_unit #(.FIFO_DEPTH(D), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fifo_count(fifo_count));

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h13572468;
  endfunction
  assign imem_data = memf(imem_addr);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(bit rdy, bit br, logic [31:0] tgt);
    bit pop, fetch;
    pop   = (q.size() > 0) && rdy;
    fetch = (q.size() < D) || pop;
    if (pop) void'(q.pop_front());
    if (br) begin
      q.delete();
      pc_m = tgt;
    end else if (fetch) begin
      q.push_back('{pc_m, memf(pc_m)});
      pc_m = pc_m + 1;
    end
  endtask

  task automatic cycle(bit rdy, bit br, logic [31:0] tgt);
    out_ready = rdy; branch_valid = br; branch_target = tgt;
    @(posedge clk);
    model_step(rdy, br, tgt);
    @(negedge clk);
  endtask

  task automatic chk_model(string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, "_addr"}, imem_addr, pc_m);
    if (q.size() > 0) begin
      chk({tag, "_pc"}, out_pc, q[0].pc);
      chk({tag, "_instr"}, out_instr, q[0].ins);
    end
  endtask

  task automatic do_reset();
    rst = 1; out_ready = 0; branch_valid = 0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    q.delete();
    pc_m = 0;
  endtask

  initial begin
    tbl[0]  = '{0, 0, 32'h0,        0, 32'h0,        0, 32'h0};
    tbl[1]  = '{0, 0, 32'h0,        1, 32'h0,        1, 32'h1};
    tbl[2]  = '{0, 0, 32'h0,        1, 32'h0,        2, 32'h2};
    tbl[3]  = '{0, 0, 32'h0,        1, 32'h0,        2, 32'h2};
    tbl[4]  = '{1, 0, 32'h0,        1, 32'h0,        2, 32'h2};
    tbl[5]  = '{1, 0, 32'h0,        1, 32'h1,        2, 32'h3};
    tbl[6]  = '{1, 1, 32'h10,       1, 32'h2,        2, 32'h4};
    tbl[7]  = '{1, 0, 32'h0,        0, 32'h0,        0, 32'h10};
    tbl[8]  = '{1, 1, 32'h20,       1, 32'h10,       1, 32'h11};
    tbl[9]  = '{1, 1, 32'h30,       0, 32'h0,        0, 32'h20};
    tbl[10] = '{1, 0, 32'h0,        0, 32'h0,        0, 32'h30};
    tbl[11] = '{1, 0, 32'h0,        1, 32'h30,       1, 32'h31};
    tbl[12] = '{0, 0, 32'h0,        1, 32'h31,       1, 32'h32};
    tbl[13] = '{1, 0, 32'h0,        1, 32'h31,       2, 32'h33};
    tbl[14] = '{1, 1, 32'hFFFFFFFF, 1, 32'h32,       2, 32'h34};
    tbl[15] = '{1, 0, 32'h0,        0, 32'h0,        0, 32'hFFFFFFFF};
    tbl[16] = '{1, 0, 32'h0,        1, 32'hFFFFFFFF, 1, 32'h0};
    tbl[17] = '{1, 0, 32'h0,        1, 32'h0,        1, 32'h1};
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_instr", i), out_instr, memf(tbl[i].pc));
      end
      cycle(tbl[i].rdy, tbl[i].br, tbl[i].tgt);
    end
    // fill the FIFO, then reset mid-stream and check the async clear
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    chk("full_count", 32'(fifo_count), D);
    #2;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("s1_valid%0d", k), 32'(out_valid), 32'(k > 0));
      if (k > 0) begin
        chk($sformatf("s1_pc%0d", k), out_pc, 32'(k - 1));
        chk($sformatf("s1_instr%0d", k), out_instr, memf(32'(k - 1)));
      end
      cycle(1, 0, 0);
    end
    for (int n = 0; n < 400; n++) begin
      bit rdy, br;
      logic [31:0] tgt;
      chk_model("rnd");
      rdy = $urandom_range(0, 3) != 0;
      br  = $urandom_range(0, 7) == 0;
      tgt = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFE : 32'($urandom_range(0, 255));
      cycle(rdy, br, tgt);
    end
    chk_model("end");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
